// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word type plus instruction-cache frame type, FSM states and width helpers.
//   Types:     word_t, icache_tag_t, icache_frame_t, icache_state_t
//   Constants: WORD_W, BYTE_OFF_W, ICACHE_TAG_MAX_W
//   Function:  icache_tag(addr, idx_w) -> tag bits above index, zero-extended
package cpu_types_pkg;
    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;
    // Widest tag occurs at the smallest legal cache (2 sets, 1 index bit).
    localparam int ICACHE_TAG_MAX_W = WORD_W - BYTE_OFF_W - 1;

    typedef logic [WORD_W-1:0]           word_t;
    typedef logic [ICACHE_TAG_MAX_W-1:0] icache_tag_t;

    typedef struct packed {
        logic        valid;
        icache_tag_t tag;
        word_t       data;
    } icache_frame_t;

    typedef enum logic {
        ICACHE_IDLE  = 1'b0,
        ICACHE_FETCH = 1'b1
    } icache_state_t;

    // Tag is everything above byte offset and index; upper bits beyond the
    // real tag width are always zero, so stored and compared tags line up.
    function automatic icache_tag_t icache_tag(input word_t addr, input int idx_w);
        word_t w_shifted;
        w_shifted = addr >> (BYTE_OFF_W + idx_w);
        return w_shifted[ICACHE_TAG_MAX_W-1:0];
    endfunction
endpackage

// File: rtl/icache_array.sv
// icache_array: direct-mapped frame storage, one combinational read port and one write port.
//   i_clk      clock
//   i_rst      synchronous active-high reset, clears valid bits only
//   i_rd_idx   read index;   o_rd_frame frame at that index
//   i_wr_en    write enable; i_wr_idx / i_wr_frame write index and frame
module icache_array
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output icache_frame_t    o_rd_frame,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  icache_frame_t    i_wr_frame
);
    logic [SETS-1:0] r_valid;
    icache_tag_t     r_tag  [SETS];
    word_t           r_data [SETS];

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_valid <= '0;
        else if (i_wr_en)
            r_valid[i_wr_idx] <= i_wr_frame.valid;
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_frame.tag;
            r_data[i_wr_idx] <= i_wr_frame.data;
        end
    end

    assign o_rd_frame.valid = r_valid[i_rd_idx];
    assign o_rd_frame.tag   = r_tag[i_rd_idx];
    assign o_rd_frame.data  = r_data[i_rd_idx];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-frame instruction cache with blocking miss handling.
//   CLK, RST            clock, synchronous active-high reset
//   imemREN, imemaddr   datapath read request and byte address
//   ihit, imemload      hit flag and instruction word (combinational)
//   iREN, iaddr         memory read request and word-aligned address
//   iwait, iload        memory busy flag and returned data
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  imemREN,
    input  word_t imemaddr,
    output logic  ihit,
    output word_t imemload,
    output logic  iREN,
    output word_t iaddr,
    input  logic  iwait,
    input  word_t iload
);
    localparam int IDX_W = $clog2(SETS);

    icache_state_t r_state, w_next_state;
    word_t         r_req_addr;
    icache_frame_t w_rd_frame, w_wr_frame;
    logic          w_hit, w_miss, w_fill;

    assign w_hit  = (r_state == ICACHE_IDLE) && imemREN && w_rd_frame.valid
                    && (w_rd_frame.tag == icache_tag(imemaddr, IDX_W));
    assign w_miss = (r_state == ICACHE_IDLE) && imemREN && !w_hit;
    // Reset wins over a completing fetch: the returned word is dropped.
    assign w_fill = (r_state == ICACHE_FETCH) && !iwait && !RST;

    assign w_wr_frame.valid = 1'b1;
    assign w_wr_frame.tag   = icache_tag(r_req_addr, IDX_W);
    assign w_wr_frame.data  = iload;

    icache_array #(.SETS(SETS), .IDX_W(IDX_W)) u_array (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_rd_idx   (imemaddr[BYTE_OFF_W +: IDX_W]),
        .o_rd_frame (w_rd_frame),
        .i_wr_en    (w_fill),
        .i_wr_idx   (r_req_addr[BYTE_OFF_W +: IDX_W]),
        .i_wr_frame (w_wr_frame)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ICACHE_IDLE;
            r_req_addr <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_miss)
                r_req_addr <= {imemaddr[WORD_W-1:BYTE_OFF_W], {BYTE_OFF_W{1'b0}}};
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state == ICACHE_IDLE)
            w_next_state = w_miss ? ICACHE_FETCH : ICACHE_IDLE;
        else
            w_next_state = iwait ? ICACHE_FETCH : ICACHE_IDLE;
    end

    // A new address seen during FETCH is ignored until the fill completes.
    always_comb begin
        ihit     = w_hit;
        imemload = w_rd_frame.data;
        iREN     = (r_state == ICACHE_FETCH);
        iaddr    = r_req_addr;
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed-vector bench for icache with hand-computed expectations.
module tb_icache;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  RST, imemREN, iwait, ihit, iREN;
    word_t imemaddr, imemload, iaddr, iload;
    int    n_vec = 0;
    int    n_bad = 0;

    // 64 sets: 0x40/0x440 still share index 16, while 0x80 (index 32) and
    // 0x100 (index 0) occupy different frames for the redirect scenario.
    icache #(.SETS(64)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    // Present a missing address, hold iwait high for 'waits' cycles, then return data.
    task automatic miss(input string tag, input word_t a, input int waits, input word_t data);
        imemREN  = 1'b1;
        imemaddr = a;
        sample();
        check({tag, " miss ihit"}, word_t'(ihit), 32'd0);
        check({tag, " miss iREN"}, word_t'(iREN), 32'd0);
        step();
        for (int i = 0; i <= waits; i++) begin
            iwait = (i < waits);
            iload = (i < waits) ? 32'hDEAD_BEEF : data;
            sample();
            check({tag, " fetch iREN"}, word_t'(iREN), 32'd1);
            check({tag, " fetch iaddr"}, iaddr, a & 32'hFFFF_FFFC);
            check({tag, " fetch ihit"}, word_t'(ihit), 32'd0);
            step();
        end
        iwait = 1'b1;
        iload = 32'hDEAD_BEEF;
    endtask

    task automatic hit(input string tag, input word_t a, input word_t data);
        imemREN  = 1'b1;
        imemaddr = a;
        sample();
        check({tag, " hit ihit"}, word_t'(ihit), 32'd1);
        check({tag, " hit data"}, imemload, data);
        check({tag, " hit iREN"}, word_t'(iREN), 32'd0);
        step();
    endtask

    initial begin
        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
        step();
        step();
        sample();
        check("rst ihit", word_t'(ihit), 32'd0);
        check("rst iREN", word_t'(iREN), 32'd0);
        check("rst iaddr", iaddr, 32'd0);
        RST = 1'b0;
        step();
        sample();
        check("idle noreq iREN", word_t'(iREN), 32'd0);
        check("idle noreq ihit", word_t'(ihit), 32'd0);
        step();

        miss("cold", 32'h0000_0040, 3, 32'h2001_0005);
        hit("cold", 32'h0000_0040, 32'h2001_0005);
        hit("repeat", 32'h0000_0040, 32'h2001_0005);
        hit("byteoff", 32'h0000_0043, 32'h2001_0005);

        miss("conflict", 32'h0000_0440, 0, 32'hAAAA_AAAA);
        hit("conflict", 32'h0000_0440, 32'hAAAA_AAAA);
        miss("evicted", 32'h0000_0040, 1, 32'h2001_0005);
        hit("evicted", 32'h0000_0040, 32'h2001_0005);

        // Redirect during FETCH: 0x80 fetch must complete before 0x100 is looked at.
        imemaddr = 32'h0000_0080;
        sample();
        check("redir miss ihit", word_t'(ihit), 32'd0);
        step();
        imemaddr = 32'h0000_0100;
        sample();
        check("redir iaddr held", iaddr, 32'h0000_0080);
        check("redir ihit", word_t'(ihit), 32'd0);
        step();
        iwait = 1'b0;
        iload = 32'h1111_0080;
        sample();
        check("redir fill iaddr", iaddr, 32'h0000_0080);
        step();
        iwait = 1'b1;
        miss("redir new", 32'h0000_0100, 0, 32'h2222_0100);
        hit("redir new", 32'h0000_0100, 32'h2222_0100);
        hit("redir old", 32'h0000_0080, 32'h1111_0080);

        // Halt: request dropped mid-fetch still fills the frame.
        imemaddr = 32'h0000_00C0;
        step();
        imemREN = 1'b0;
        iwait   = 1'b0;
        iload   = 32'h3333_00C0;
        sample();
        check("halt fetch iREN", word_t'(iREN), 32'd1);
        step();
        iwait = 1'b1;
        sample();
        check("halt ihit", word_t'(ihit), 32'd0);
        check("halt iREN", word_t'(iREN), 32'd0);
        step();
        hit("halt", 32'h0000_00C0, 32'h3333_00C0);

        // Reset in FETCH with iwait low: fetch abandoned, all frames invalid.
        imemaddr = 32'h0000_0200;
        step();
        sample();
        check("rstfetch iREN", word_t'(iREN), 32'd1);
        RST   = 1'b1;
        iwait = 1'b0;
        iload = 32'h4444_0200;
        step();
        RST   = 1'b0;
        iwait = 1'b1;
        imemaddr = 32'h0000_0080;
        sample();
        check("rstfetch iREN after", word_t'(iREN), 32'd0);
        check("rstfetch iaddr", iaddr, 32'd0);
        check("rstfetch 0x80 ihit", word_t'(ihit), 32'd0);
        step();
        sample();
        check("rstfetch refetch iREN", word_t'(iREN), 32'd1);
        check("rstfetch refetch iaddr", iaddr, 32'h0000_0080);
        iwait = 1'b0;
        iload = 32'h5555_0080;
        step();
        iwait = 1'b1;
        hit("rstfetch refill", 32'h0000_0080, 32'h5555_0080);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0200;
        sample();
        check("rstfetch 0x200 not filled", word_t'(ihit), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
